axil2wbm: RTL and testbench
===========================

AXIL2WBM -- requirements
Module: axil2wbm

Interface
REQ-001 SHALL have parameter C_AXI_ADDR_WIDTH, default 28, AXI byte-address width.
REQ-002 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI and WB data width.
REQ-003 SHALL have derived parameter AW = C_AXI_ADDR_WIDTH - clog2(C_AXI_DATA_WIDTH/8), WB word-address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, WB wait limit (used only with the timeout macro).
REQ-005 SHALL have the following ports:
- i_clk  in  1  sole clock.
- i_reset_n  in  1  reset; one clock, asynchronous, active-low.
- i_axi_awvalid/o_axi_awready  in/out  1/1  AW handshake.
- i_axi_awaddr  in  C_AXI_ADDR_WIDTH.
- i_axi_wvalid/o_axi_wready  in/out  1/1.
- i_axi_wdata  in  DW.
- i_axi_wstrb  in  DW/8.
- o_axi_bvalid/i_axi_bready  out/in  1/1.
- o_axi_bresp  out  2.
- i_axi_arvalid/o_axi_arready  in/out  1/1.
- i_axi_araddr  in  C_AXI_ADDR_WIDTH.
- o_axi_rvalid/i_axi_rready  out/in  1/1.
- o_axi_rdata  out  DW.
- o_axi_rresp  out  2.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  WB pipelined master.
- o_wb_addr  out  AW.
- o_wb_data  out  DW.
- o_wb_sel  out  DW/8.
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each.
- i_wb_data  in  DW.

Function
REQ-006 SHALL be an AXI4-Lite slave issuing single WB pipelined transactions, one outstanding at a time.
REQ-007 SHALL use states IDLE, REQ (cyc=stb=1), WAIT (cyc=1, stb=0), BRESP and RRESP.
REQ-008 In IDLE, a write SHALL be eligible only when awvalid and wvalid are both high; a read SHALL be eligible when arvalid is high.
REQ-009 When both are eligible in the same cycle, SHALL serve the type not served last; after reset the write SHALL win.
REQ-010 On acceptance, SHALL pulse awready and wready together (write) or arready (read) for exactly one cycle, then enter REQ on the next cycle.
REQ-011 SHALL drive o_wb_addr = addr[C_AXI_ADDR_WIDTH-1:clog2(DW/8)]; write: o_wb_data=wdata, o_wb_sel=wstrb, o_wb_we=1; read: o_wb_sel all ones, o_wb_we=0.
REQ-012 In REQ, SHALL go to WAIT when i_wb_stall=0; when ack or err arrives in the same cycle as the accepting stb, SHALL go directly to the response state.
REQ-013 On ack or err, SHALL drop cyc that same clock edge, register i_wb_data into o_axi_rdata (reads), and set resp to OKAY 2'b00 on ack or SLVERR 2'b10 on err.
REQ-014 SHALL hold bvalid or rvalid, with data and resp stable, until bready or rready; on the handshake, SHALL return to IDLE.
REQ-015 SHALL ignore ack and err outside REQ/WAIT; SHALL never assert stb without cyc.
REQ-016 Minimum latency, from AXI accept to valid response, with zero stall and ack on the first stb cycle: 2 cycles.

Reset
REQ-017 SHALL, on asynchronous assertion of i_reset_n=0, immediately clear cyc, stb, all AXI ready and valid outputs, the state (to IDLE) and the priority bit.
REQ-018 SHALL clear resp and rdata to 0 on reset.
REQ-019 A reset mid-transaction SHALL abandon it with no response generated.
REQ-020 SHALL release reset synchronously in the design that instantiates this block.

Configuration
REQ-021 Macro AXIL2WBM_TIMEOUT_EN, when defined: a counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT; on reaching TIMEOUT_CYCLES without ack or err, SHALL drop cyc and stb and respond SLVERR.
REQ-022 When AXIL2WBM_TIMEOUT_EN is undefined, SHALL include no counter and SHALL wait indefinitely.

Structure
REQ-023 Response codes (OKAY, SLVERR) and state encodings SHALL live in shared package axi_defs_pkg.
REQ-024 SHALL be a single flat module with no sub-module; the handshakes are simple enough that no skid buffer is needed.

Verification
REQ-025 Write 0x0000_0010, data 0xDEADBEEF, strb 0xF, stall=0, ack next cycle -> exactly one stb, addr 0x4, sel 0xF, bresp 2'b00.
REQ-026 Read 0x0000_0020, stall held 3 cycles, ack returns 0x12345678 -> stb held 4 cycles, rdata 0x12345678, rresp 2'b00.
REQ-027 Write and read valid in the same cycle, twice in a row -> service order write, read, write, read.
REQ-028 i_wb_err instead of ack on a read -> rresp 2'b10, cyc low next cycle.
REQ-029 i_reset_n low during WAIT -> cyc=0 and bvalid=0 immediately; the next write completes normally.
REQ-030 With AXIL2WBM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> SLVERR after 8 cycles, cyc dropped.

Source files
------------

// File: rtl/axi_defs_pkg.sv
// Shared AXI/WB bridge definitions: response codes, bridge state encoding
// and a small helper that maps a bus outcome onto an AXI response code.
package axi_defs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BRESP = 3'd3,
    ST_RRESP = 3'd4
  } axil_state_t;

  // An error or a missing ack (timeout) reports SLVERR, a clean ack reports OKAY
  function automatic logic [1:0] bus_resp(input logic failed);
    return failed ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil2wbm.sv
// AXI4-Lite slave to Wishbone pipelined master bridge.
// One transaction is in flight at a time; simultaneous read and write
// requests alternate, with writes winning first after reset.
// Optional bus-watchdog: define AXIL2WBM_TIMEOUT_EN to abort a WB access
// with SLVERR after TIMEOUT_CYCLES cycles without ack or err.
module axil2wbm
  import axi_defs_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES   = 255,
  localparam int LSB = $clog2(C_AXI_DATA_WIDTH / 8),
  localparam int AW  = C_AXI_ADDR_WIDTH - LSB
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_axi_awvalid,
  output logic                          o_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
  input  logic                          i_axi_wvalid,
  output logic                          o_axi_wready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,
  output logic                          o_axi_bvalid,
  input  logic                          i_axi_bready,
  output logic [1:0]                    o_axi_bresp,
  input  logic                          i_axi_arvalid,
  output logic                          o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_araddr,
  output logic                          o_axi_rvalid,
  input  logic                          i_axi_rready,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_rdata,
  output logic [1:0]                    o_axi_rresp,
  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  output logic                          o_wb_we,
  output logic [AW-1:0]                 o_wb_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_wb_data,
  output logic [C_AXI_DATA_WIDTH/8-1:0] o_wb_sel,
  input  logic                          i_wb_stall,
  input  logic                          i_wb_ack,
  input  logic                          i_wb_err,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_wb_data
);

  axil_state_t state;
  logic        last_write;
  logic [1:0]  resp_q;
  logic        wr_ok;
  logic        rd_ok;
  logic        in_bus;
  logic        timed_out;
  logic        wb_done;
  logic        done_err;

  assign wr_ok  = i_axi_awvalid && i_axi_wvalid;
  assign rd_ok  = i_axi_arvalid;
  assign in_bus = (state == ST_REQ) || (state == ST_WAIT);

  // The byte-lane bits of the AXI address never reach the word-addressed bus
  if (LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{i_axi_awaddr[LSB-1:0], i_axi_araddr[LSB-1:0]};
  end

`ifdef AXIL2WBM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // Counts cycles spent on the bus; sits at zero so every new request starts fresh
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_cnt <= '0;
    end else if (!in_bus) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timed_out = in_bus && (tmo_cnt == TMO_LAST);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  // A bus access ends on ack, err, or the watchdog; anything but a clean ack is an error
  assign wb_done  = in_bus && (i_wb_ack || i_wb_err || timed_out);
  assign done_err = i_wb_err || !i_wb_ack;

  assign o_axi_bresp = resp_q;
  assign o_axi_rresp = resp_q;

  // Bridge FSM: arbitrate and accept in IDLE, run the WB access, then hold the AXI response
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      last_write    <= 1'b0;
      o_axi_awready <= 1'b0;
      o_axi_wready  <= 1'b0;
      o_axi_arready <= 1'b0;
      o_axi_bvalid  <= 1'b0;
      o_axi_rvalid  <= 1'b0;
      o_axi_rdata   <= '0;
      resp_q        <= RESP_OKAY;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_addr     <= '0;
      o_wb_data     <= '0;
      o_wb_sel      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (o_axi_awready) begin
            o_axi_awready <= 1'b0;
            o_axi_wready  <= 1'b0;
            if (wr_ok) begin
              o_wb_addr  <= i_axi_awaddr[C_AXI_ADDR_WIDTH-1:LSB];
              o_wb_data  <= i_axi_wdata;
              o_wb_sel   <= i_axi_wstrb;
              o_wb_we    <= 1'b1;
              o_wb_cyc   <= 1'b1;
              o_wb_stb   <= 1'b1;
              last_write <= 1'b1;
              state      <= ST_REQ;
            end
          end else if (o_axi_arready) begin
            o_axi_arready <= 1'b0;
            if (rd_ok) begin
              o_wb_addr  <= i_axi_araddr[C_AXI_ADDR_WIDTH-1:LSB];
              o_wb_sel   <= '1;
              o_wb_we    <= 1'b0;
              o_wb_cyc   <= 1'b1;
              o_wb_stb   <= 1'b1;
              last_write <= 1'b0;
              state      <= ST_REQ;
            end
          end else if (wr_ok && (!rd_ok || !last_write)) begin
            o_axi_awready <= 1'b1;
            o_axi_wready  <= 1'b1;
          end else if (rd_ok) begin
            o_axi_arready <= 1'b1;
          end
        end

        ST_REQ, ST_WAIT: begin
          if (wb_done) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            resp_q   <= bus_resp(done_err);
            if (o_wb_we) begin
              o_axi_bvalid <= 1'b1;
              state        <= ST_BRESP;
            end else begin
              o_axi_rdata  <= i_wb_data;
              o_axi_rvalid <= 1'b1;
              state        <= ST_RRESP;
            end
          end else if ((state == ST_REQ) && !i_wb_stall) begin
            o_wb_stb <= 1'b0;
            state    <= ST_WAIT;
          end
        end

        ST_BRESP: begin
          if (i_axi_bready) begin
            o_axi_bvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end

        ST_RRESP: begin
          if (i_axi_rready) begin
            o_axi_rvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil2wbm.sv
// Directed self-checking bench for axil2wbm.
// The watchdog step runs only when AXIL2WBM_TIMEOUT_EN is defined.
module tb_axil2wbm;
  import axi_defs_pkg::*;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 32;
  localparam int WB_AW  = 26;

  localparam int S_AWREADY  = 0;
  localparam int S_ARREADY  = 1;
  localparam int S_STB      = 2;
  localparam int S_BVALID   = 3;
  localparam int S_RVALID   = 4;
  localparam int S_ANYREADY = 5;
  localparam int S_ANYVALID = 6;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                awvalid, awready, wvalid, wready, bvalid, bready;
  logic                arvalid, arready, rvalid, rready;
  logic [ADDR_W-1:0]   awaddr, araddr;
  logic [DATA_W-1:0]   wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0]          bresp, rresp;
  logic                wb_cyc, wb_stb, wb_we;
  logic [WB_AW-1:0]    wb_addr;
  logic [DATA_W-1:0]   wb_wdata, wb_rdata;
  logic [DATA_W/8-1:0] wb_sel;
  logic                wb_stall, wb_ack, wb_err;

  int checks = 0;
  int errors = 0;
  int stb_cycles = 0;
  int stb_no_cyc = 0;

  axil2wbm #(
    .C_AXI_ADDR_WIDTH(ADDR_W),
    .C_AXI_DATA_WIDTH(DATA_W),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_axi_awvalid(awvalid),
    .o_axi_awready(awready),
    .i_axi_awaddr (awaddr),
    .i_axi_wvalid (wvalid),
    .o_axi_wready (wready),
    .i_axi_wdata  (wdata),
    .i_axi_wstrb  (wstrb),
    .o_axi_bvalid (bvalid),
    .i_axi_bready (bready),
    .o_axi_bresp  (bresp),
    .i_axi_arvalid(arvalid),
    .o_axi_arready(arready),
    .i_axi_araddr (araddr),
    .o_axi_rvalid (rvalid),
    .i_axi_rready (rready),
    .o_axi_rdata  (rdata),
    .o_axi_rresp  (rresp),
    .o_wb_cyc     (wb_cyc),
    .o_wb_stb     (wb_stb),
    .o_wb_we      (wb_we),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_wdata),
    .o_wb_sel     (wb_sel),
    .i_wb_stall   (wb_stall),
    .i_wb_ack     (wb_ack),
    .i_wb_err     (wb_err),
    .i_wb_data    (wb_rdata)
  );

  always #5 clk = ~clk;

  // Bus monitor: counts strobe cycles and flags any strobe outside a cycle
  always @(posedge clk) begin
    if (wb_stb && wb_cyc) stb_cycles++;
    if (wb_stb && !wb_cyc) stb_no_cyc++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic aw, input logic w, input logic ar,
                               input logic [ADDR_W-1:0] a_wr, input logic [DATA_W-1:0] d_wr,
                               input logic [DATA_W/8-1:0] strb, input logic [ADDR_W-1:0] a_rd);
    awvalid = aw;
    wvalid  = w;
    arvalid = ar;
    awaddr  = a_wr;
    wdata   = d_wr;
    wstrb   = strb;
    araddr  = a_rd;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sigVal(input int sel);
    case (sel)
      S_AWREADY:  return awready;
      S_ARREADY:  return arready;
      S_STB:      return wb_stb && wb_cyc;
      S_BVALID:   return bvalid;
      S_RVALID:   return rvalid;
      S_ANYREADY: return awready || arready;
      S_ANYVALID: return bvalid || rvalid;
      default:    return 1'b0;
    endcase
  endfunction

  // Waits on falling edges for a DUT signal, returning how many edges it took
  task automatic waitFor(input string tag, input int sel, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sigVal(sel)) begin
        n = k;
        break;
      end
    end
    checkOutput(tag, 64'(sigVal(sel)), 64'd1);
  endtask

  // Linear directed sequence
  initial begin
    int n;
    int stb_base;
    logic got_write;
    logic exp_order [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    reset_n  = 1'b0;
    bready   = 1'b0;
    rready   = 1'b0;
    wb_stall = 1'b0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_rdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst cyc", 64'(wb_cyc), 64'd0);
    checkOutput("rst stb", 64'(wb_stb), 64'd0);
    checkOutput("rst awready", 64'(awready), 64'd0);
    checkOutput("rst wready", 64'(wready), 64'd0);
    checkOutput("rst arready", 64'(arready), 64'd0);
    checkOutput("rst bvalid", 64'(bvalid), 64'd0);
    checkOutput("rst rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst bresp", 64'(bresp), 64'd0);
    checkOutput("rst rdata", 64'(rdata), 64'd0);
    stepCycle();
    reset_n = 1'b1;

    // Single write, stall-free, ack one cycle after the strobe
    stepCycle();
    stb_base = stb_cycles;
    applyStimulus(1'b1, 1'b1, 1'b0, 28'h10, 32'hDEADBEEF, 4'hF, '0);
    waitFor("wr awready", S_AWREADY, n);
    checkOutput("wr wready", 64'(wready), 64'd1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("wr awready pulse", 64'(awready), 64'd0);
    checkOutput("wr stb", 64'(wb_stb), 64'd1);
    checkOutput("wr we", 64'(wb_we), 64'd1);
    checkOutput("wr addr", 64'(wb_addr), 64'h4);
    checkOutput("wr data", 64'(wb_wdata), 64'hDEADBEEF);
    checkOutput("wr sel", 64'(wb_sel), 64'hF);
    stepCycle();
    wb_ack = 1'b1;
    @(negedge clk);
    checkOutput("wr wait stb", 64'(wb_stb), 64'd0);
    checkOutput("wr wait cyc", 64'(wb_cyc), 64'd1);
    stepCycle();
    wb_ack = 1'b0;
    @(negedge clk);
    checkOutput("wr bvalid", 64'(bvalid), 64'd1);
    checkOutput("wr bresp", 64'(bresp), 64'(RESP_OKAY));
    checkOutput("wr cyc drop", 64'(wb_cyc), 64'd0);
    checkOutput("wr one stb", 64'(stb_cycles - stb_base), 64'd1);
    stepCycle();
    stepCycle();
    @(negedge clk);
    checkOutput("wr bvalid hold", 64'(bvalid), 64'd1);
    stepCycle();
    bready = 1'b1;
    stepCycle();
    bready = 1'b0;
    @(negedge clk);
    checkOutput("wr bvalid clear", 64'(bvalid), 64'd0);

    // Minimum latency: ack on the first strobe cycle gives bvalid two cycles after accept
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 28'h44, 32'h0BADF00D, 4'h3, '0);
    waitFor("lat awready", S_AWREADY, n);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("lat addr", 64'(wb_addr), 64'h11);
    checkOutput("lat sel", 64'(wb_sel), 64'h3);
    wb_ack = 1'b1;
    stepCycle();
    wb_ack = 1'b0;
    @(negedge clk);
    checkOutput("lat bvalid", 64'(bvalid), 64'd1);
    checkOutput("lat cyc", 64'(wb_cyc), 64'd0);
    stepCycle();
    bready = 1'b1;
    stepCycle();
    bready = 1'b0;

    // Read with the strobe stalled for three cycles
    stepCycle();
    wb_stall = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0, 28'h20);
    waitFor("rd arready", S_ARREADY, n);
    stepCycle();
    stb_base = stb_cycles;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("rd stb", 64'(wb_stb), 64'd1);
    checkOutput("rd we", 64'(wb_we), 64'd0);
    checkOutput("rd addr", 64'(wb_addr), 64'h8);
    checkOutput("rd sel", 64'(wb_sel), 64'hF);
    stepCycle();
    stepCycle();
    stepCycle();
    wb_stall = 1'b0;
    @(negedge clk);
    checkOutput("rd stb 4th", 64'(wb_stb), 64'd1);
    stepCycle();
    wb_ack   = 1'b1;
    wb_rdata = 32'h12345678;
    stepCycle();
    wb_ack   = 1'b0;
    wb_rdata = '0;
    @(negedge clk);
    checkOutput("rd rvalid", 64'(rvalid), 64'd1);
    checkOutput("rd rdata", 64'(rdata), 64'h12345678);
    checkOutput("rd rresp", 64'(rresp), 64'(RESP_OKAY));
    checkOutput("rd stb count", 64'(stb_cycles - stb_base), 64'd4);
    stepCycle();
    rready = 1'b1;
    stepCycle();
    rready = 1'b0;

    // Read answered with err; a later stray ack must not disturb the held response
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0, 28'h30);
    waitFor("err arready", S_ARREADY, n);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    wb_err   = 1'b1;
    wb_rdata = 32'h55AA55AA;
    stepCycle();
    wb_err   = 1'b0;
    wb_rdata = '0;
    @(negedge clk);
    checkOutput("err cyc", 64'(wb_cyc), 64'd0);
    checkOutput("err rvalid", 64'(rvalid), 64'd1);
    checkOutput("err rresp", 64'(rresp), 64'(RESP_SLVERR));
    checkOutput("err rdata", 64'(rdata), 64'h55AA55AA);
    stepCycle();
    wb_ack   = 1'b1;
    wb_rdata = 32'hCAFEF00D;
    stepCycle();
    wb_ack   = 1'b0;
    wb_rdata = '0;
    @(negedge clk);
    checkOutput("stray rvalid", 64'(rvalid), 64'd1);
    checkOutput("stray rresp", 64'(rresp), 64'(RESP_SLVERR));
    checkOutput("stray rdata", 64'(rdata), 64'h55AA55AA);
    checkOutput("stray cyc", 64'(wb_cyc), 64'd0);
    stepCycle();
    rready = 1'b1;
    stepCycle();
    rready = 1'b0;

    // Reset asserted while the write waits for its ack
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 28'h100, 32'h11112222, 4'hF, '0);
    waitFor("rst wr awready", S_AWREADY, n);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    stepCycle();
    @(negedge clk);
    checkOutput("rst wait cyc", 64'(wb_cyc), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async rst cyc", 64'(wb_cyc), 64'd0);
    checkOutput("async rst stb", 64'(wb_stb), 64'd0);
    checkOutput("async rst bvalid", 64'(bvalid), 64'd0);
    stepCycle();
    reset_n = 1'b1;
    stepCycle();
    @(negedge clk);
    checkOutput("abandoned bvalid", 64'(bvalid), 64'd0);

    // Both requests held valid: service alternates, write first after reset
    stepCycle();
    bready = 1'b1;
    rready = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 28'h200, 32'hA5A5A5A5, 4'hF, 28'h300);
    for (int i = 0; i < 4; i++) begin
      waitFor("ord ready", S_ANYREADY, n);
      got_write = awready;
      checkOutput($sformatf("ord slot %0d", i), 64'(got_write), 64'(exp_order[i]));
      stepCycle();
      if (got_write) begin
        awvalid = 1'b0;
        wvalid  = 1'b0;
      end else begin
        arvalid = 1'b0;
      end
      waitFor("ord stb", S_STB, n);
      checkOutput($sformatf("ord addr %0d", i), 64'(wb_addr), exp_order[i] ? 64'h80 : 64'hC0);
      wb_ack   = 1'b1;
      wb_rdata = 32'h0000_1000 + i;
      stepCycle();
      wb_ack   = 1'b0;
      wb_rdata = '0;
      waitFor("ord resp", S_ANYVALID, n);
      checkOutput($sformatf("ord bvalid %0d", i), 64'(bvalid), 64'(exp_order[i]));
      checkOutput($sformatf("ord resp %0d", i), 64'(exp_order[i] ? bresp : rresp), 64'(RESP_OKAY));
      stepCycle();
      if (i < 3) begin
        if (got_write) begin
          awvalid = 1'b1;
          wvalid  = 1'b1;
        end else begin
          arvalid = 1'b1;
        end
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    bready = 1'b0;
    rready = 1'b0;

`ifdef AXIL2WBM_TIMEOUT_EN
    // Read that never gets an ack is cut off by the watchdog
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0, 28'h40);
    waitFor("tmo arready", S_ARREADY, n);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    waitFor("tmo stb", S_STB, n);
    waitFor("tmo rvalid", S_RVALID, n);
    checkOutput("tmo cycles", 64'(n), 64'd8);
    checkOutput("tmo rresp", 64'(rresp), 64'(RESP_SLVERR));
    checkOutput("tmo cyc", 64'(wb_cyc), 64'd0);
    checkOutput("tmo stb off", 64'(wb_stb), 64'd0);
    stepCycle();
    rready = 1'b1;
    stepCycle();
    rready = 1'b0;
`endif

    stepCycle();
    checkOutput("stb without cyc", 64'(stb_no_cyc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
